systolic_skew_feeder: RTL and testbench

//  Feeds one operand tile into the systolic data-setup skew bank (lane i -> shift chain of depth i).
//  - Accepts a K-beat stream of N-lane row vectors over a valid/ready handshake.
//  - Registers each beat onto the lane outputs and generates the common shift enable.
//  - Appends N-1 zero beats so every skew chain drains, then pulses Done.
//  - Sits between the operand buffer read port and the per-lane skew shift registers.

---
 rtl/systolic_skew_feeder.sv | 134 +++++++++++++
 tb/tb_systolic_skew_feeder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - operand tile feeder for the systolic skew bank
// Optional FEEDER_STALL_CNT_EN adds the Stall_Count port (LOAD cycles without a beat).
module systolic_skew_feeder #(
   parameter int N = 4,
   parameter int DATA_WIDTH = 32,
   parameter int K_MAX = 256,
   localparam int CNT_W = $clog2(K_MAX + 1)
) (
   input  logic                    CLK,
   input  logic                    ASYNC_RST,
   input  logic                    SYNC_RST,
   input  logic                    Start,
   input  logic [CNT_W-1:0]        K_Len,
   input  logic                    In_Valid,
   output logic                    In_Ready,
   input  logic [N*DATA_WIDTH-1:0] In_Data,
   output logic [N*DATA_WIDTH-1:0] Lane_Data,
   output logic                    Shift_EN,
   output logic                    Busy,
   output logic                    Done
`ifdef FEEDER_STALL_CNT_EN
   ,
   output logic [31:0]             Stall_Count
`endif
);

   localparam int DRN_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FIN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   k_lat, beat_cnt;
   logic [DRN_W-1:0]   drain_cnt;
   logic               beat_last;
   logic               drain_last;

   assign beat_last  = (beat_cnt == k_lat - CNT_W'(1));
   assign drain_last = (drain_cnt == DRN_W'(N - 2));

   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         state_q <= IDLE;
      end else if (SYNC_RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      In_Ready = 1'b0;
      Busy     = 1'b1;
      case (state_q)
         IDLE: begin
            Busy = 1'b0;
            if (Start) state_d = (K_Len != '0) ? LOAD : FIN;
         end
         LOAD: begin
            In_Ready = 1'b1;
            if (In_Valid && beat_last) state_d = (N > 1) ? DRAIN : FIN;
         end
         DRAIN: begin
            if (drain_last) state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Done is registered out of FIN, so it lands on the cycle after the last drain beat.
   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         k_lat     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         Lane_Data <= '0;
         Shift_EN  <= 1'b0;
         Done      <= 1'b0;
      end else if (SYNC_RST) begin
         k_lat     <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         Lane_Data <= '0;
         Shift_EN  <= 1'b0;
         Done      <= 1'b0;
      end else begin
         Shift_EN <= 1'b0;
         Done     <= 1'b0;
         case (state_q)
            IDLE: begin
               if (Start) begin
                  k_lat     <= (K_Len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : K_Len;
                  beat_cnt  <= '0;
                  drain_cnt <= '0;
               end
            end
            LOAD: begin
               if (In_Valid) begin
                  Lane_Data <= In_Data;
                  Shift_EN  <= 1'b1;
                  beat_cnt  <= beat_cnt + CNT_W'(1);
               end
            end
            DRAIN: begin
               Lane_Data <= '0;
               Shift_EN  <= 1'b1;
               drain_cnt <= drain_cnt + DRN_W'(1);
            end
            FIN: begin
               Done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef FEEDER_STALL_CNT_EN
   always_ff @(posedge CLK or negedge ASYNC_RST) begin
      if (!ASYNC_RST) begin
         Stall_Count <= '0;
      end else if (SYNC_RST) begin
         Stall_Count <= '0;
      end else if (state_q == IDLE && Start) begin
         Stall_Count <= '0;
      end else if (state_q == LOAD && !In_Valid && Stall_Count != 32'hFFFF_FFFF) begin
         Stall_Count <= Stall_Count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - scoreboard bench for systolic_skew_feeder
module tb_systolic_skew_feeder;
   localparam int N = 4;
   localparam int DW = 8;
   localparam int K_MAX = 16;
   localparam int CNT_W = $clog2(K_MAX + 1);
   localparam int W = N * DW;

   logic             CLK = 1'b0;
   logic             ASYNC_RST = 1'b0;
   logic             SYNC_RST = 1'b0;
   logic             Start = 1'b0;
   logic [CNT_W-1:0] K_Len = '0;
   logic             In_Valid = 1'b0;
   logic             In_Ready;
   logic [W-1:0]     In_Data = '0;
   logic [W-1:0]     Lane_Data;
   logic             Shift_EN;
   logic             Busy;
   logic             Done;
`ifdef FEEDER_STALL_CNT_EN
   logic [31:0]      Stall_Count;
`endif

   int vectors = 0;
   int miscompares = 0;

   systolic_skew_feeder #(.N(N), .DATA_WIDTH(DW), .K_MAX(K_MAX)) dut (
      .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST), .Start(Start), .K_Len(K_Len),
      .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data), .Lane_Data(Lane_Data),
      .Shift_EN(Shift_EN), .Busy(Busy), .Done(Done)
`ifdef FEEDER_STALL_CNT_EN
      , .Stall_Count(Stall_Count)
`endif
   );

   always #5 CLK = ~CLK;

   // Drives one tile and scoreboards every lane beat; stall cycles are inserted after beat stall_beat.
   task automatic run_tile(input string name, input int k_drive, input int k_exp,
                           input int stall_beat, input int stall_len,
                           input int restart_cyc, input int restart_k);
      logic [W-1:0] exp_q[$];
      logic [W-1:0] d, ex, last_beat;
      int sent, stall_rem, en_cnt, rdy_cnt, t0, done_cyc;
      sent = 0; stall_rem = stall_len; en_cnt = 0; rdy_cnt = 0; t0 = -1; done_cyc = -1;
      last_beat = '0;
      @(negedge CLK);
      Start = 1'b1; K_Len = CNT_W'(k_drive); In_Valid = 1'b0;
      for (int cyc = 0; cyc < 200 && done_cyc < 0; cyc++) begin
         @(negedge CLK);
         if (Shift_EN) begin
            en_cnt++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL %s extra_shift cyc=%0d lane=%h expected no beat", name, cyc, Lane_Data);
            end else begin
               ex = exp_q.pop_front();
               if (Lane_Data !== ex) begin
                  miscompares++;
                  $display("FAIL %s lane_data cyc=%0d got=%h exp=%h", name, cyc, Lane_Data, ex);
               end
            end
         end else if (In_Ready && sent > 0) begin
            vectors++;
            if (Lane_Data !== last_beat) begin
               miscompares++;
               $display("FAIL %s lane_hold cyc=%0d got=%h exp=%h", name, cyc, Lane_Data, last_beat);
            end
         end
         if (In_Ready) rdy_cnt++;
         if (Done) begin
            done_cyc = cyc;
            vectors++;
            if (Busy !== 1'b0) begin
               miscompares++;
               $display("FAIL %s busy_at_done got=%b exp=0", name, Busy);
            end
         end
         Start = (cyc == restart_cyc);
         K_Len = (cyc == restart_cyc) ? CNT_W'(restart_k) : '0;
         d = $urandom;
         In_Valid = 1'b0;
         In_Data = d;
         if (In_Ready && sent < k_exp) begin
            if (sent == stall_beat && stall_rem > 0) begin
               stall_rem--;
            end else begin
               In_Valid = 1'b1;
               exp_q.push_back(d);
               last_beat = d;
               if (t0 < 0) t0 = cyc;
               sent++;
               if (sent == k_exp) for (int z = 0; z < N - 1; z++) exp_q.push_back('0);
            end
         end
      end
      In_Valid = 1'b0; Start = 1'b0;
      vectors++;
      if (done_cyc < 0) begin
         miscompares++;
         $display("FAIL %s done_timeout got=none exp=done", name);
      end else if (done_cyc - t0 != k_exp + N + stall_len) begin
         miscompares++;
         $display("FAIL %s done_latency got=%0d exp=%0d", name, done_cyc - t0, k_exp + N + stall_len);
      end
      vectors++;
      if (en_cnt != k_exp + N - 1) begin
         miscompares++;
         $display("FAIL %s shift_count got=%0d exp=%0d", name, en_cnt, k_exp + N - 1);
      end
      vectors++;
      if (rdy_cnt != k_exp + stall_len) begin
         miscompares++;
         $display("FAIL %s ready_count got=%0d exp=%0d", name, rdy_cnt, k_exp + stall_len);
      end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s scoreboard_left got=%0d exp=0", name, exp_q.size());
      end
`ifdef FEEDER_STALL_CNT_EN
      vectors++;
      if (Stall_Count !== 32'(stall_len)) begin
         miscompares++;
         $display("FAIL %s stall_count got=%0d exp=%0d", name, Stall_Count, stall_len);
      end
`endif
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({Busy, In_Ready, Shift_EN, Done, Lane_Data} !== '0) begin
         miscompares++;
         $display("FAIL reset_hold got=%b%b%b%b %h exp=0", Busy, In_Ready, Shift_EN, Done, Lane_Data);
      end
      @(negedge CLK); ASYNC_RST = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         vectors++;
         if (Busy !== 1'b0 || In_Ready !== 1'b0 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b rdy=%b done=%b exp=0", Busy, In_Ready, Done);
         end
      end
      Start = 1'b1; K_Len = CNT_W'(2);
      @(negedge CLK); Start = 1'b0; In_Valid = 1'b1; In_Data = 32'hA5C3_5A3C;
      @(negedge CLK); In_Valid = 1'b0;
      vectors++;
      if (Shift_EN !== 1'b1 || Lane_Data !== 32'hA5C3_5A3C) begin
         miscompares++;
         $display("FAIL reset_pre_beat got en=%b lane=%h exp en=1 lane=a5c35a3c", Shift_EN, Lane_Data);
      end
      #2 ASYNC_RST = 1'b0;
      #1;
      vectors++;
      if ({Busy, In_Ready, Shift_EN, Done, Lane_Data} !== '0) begin
         miscompares++;
         $display("FAIL reset_async got=%b%b%b%b %h exp=0", Busy, In_Ready, Shift_EN, Done, Lane_Data);
      end
      @(negedge CLK); ASYNC_RST = 1'b1;
      @(negedge CLK);
      vectors++;
      if (Busy !== 1'b0 || In_Ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_release got busy=%b rdy=%b exp=0", Busy, In_Ready);
      end
   endtask

   task automatic test_k_zero();
      int done_c;
      done_c = -1;
      @(negedge CLK); Start = 1'b1; K_Len = '0;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         Start = 1'b0;
         vectors++;
         if (Shift_EN !== 1'b0 || In_Ready !== 1'b0) begin
            miscompares++;
            $display("FAIL kzero_quiet c=%0d got en=%b rdy=%b exp=0", c, Shift_EN, In_Ready);
         end
         if (Done === 1'b1 && done_c < 0) done_c = c;
      end
      vectors++;
      if (done_c != 2) begin
         miscompares++;
         $display("FAIL kzero_done got=%0d exp=2", done_c);
      end
   endtask

   task automatic test_sync_rst();
      @(negedge CLK); Start = 1'b1; K_Len = CNT_W'(2);
      @(negedge CLK); Start = 1'b0; In_Valid = 1'b1; In_Data = $urandom;
      @(negedge CLK); In_Data = $urandom;
      @(negedge CLK); In_Valid = 1'b0;
      @(negedge CLK);
      vectors++;
      if (Busy !== 1'b1 || In_Ready !== 1'b0 || Shift_EN !== 1'b1) begin
         miscompares++;
         $display("FAIL srst_in_drain got busy=%b rdy=%b en=%b exp=1 0 1", Busy, In_Ready, Shift_EN);
      end
      SYNC_RST = 1'b1;
      @(negedge CLK); SYNC_RST = 1'b0;
      vectors++;
      if ({Busy, Shift_EN, Done, Lane_Data} !== '0) begin
         miscompares++;
         $display("FAIL srst_clear got=%b%b%b %h exp=0", Busy, Shift_EN, Done, Lane_Data);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         vectors++;
         if (Done !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL srst_no_done got done=%b busy=%b exp=0", Done, Busy);
         end
      end
      run_tile("srst_retile", 4, 4, -1, 0, -1, 0);
   endtask

   initial begin
      test_reset();
      run_tile("back_to_back", 3, 3, -1, 0, -1, 0);
      run_tile("stall", 3, 3, 1, 2, -1, 0);
      test_k_zero();
      run_tile("busy_start", 3, 3, -1, 0, 1, 5);
      run_tile("k_max", 16, 16, -1, 0, -1, 0);
      run_tile("k_clamp", 31, 16, 5, 3, -1, 0);
      run_tile("k_one", 1, 1, -1, 0, -1, 0);
      test_sync_rst();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
